// File: rtl/hwcnn_pkg.sv
// Shared definitions for the CNN accelerator front end.
// Holds the default instruction/DDR geometry and the fetcher FSM state type.
package hwcnn_pkg;

   localparam int INST_LEN       = 220;
   localparam int DDR_DATA_LEN   = 512;
   localparam int BYTES_PER_WORD = 64;
   localparam int SLOT_STRIDE    = 256;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      FETCH  = 2'd2,
      FINISH = 2'd3
   } fetch_state_t;

endpackage

// File: rtl/inst_queue.sv
// First-word-fall-through register FIFO for instructions.
// Two write lanes (lane 1 is written only together with lane 0, and lands
// behind it) and one read port. The head is valid whenever empty is low.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push0, data0    write the first lane
//   push1, data1    write the second lane (ignored unless push0)
//   pop             remove the head; ignored while empty
//   head            current head entry (zero while empty)
//   count, free     occupied / free entries
//   empty           no entries held
module inst_queue #(
   parameter int WIDTH = 220,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push0,
   input  logic                     push1,
   input  logic [WIDTH-1:0]         data0,
   input  logic [WIDTH-1:0]         data1,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count,
   output logic [$clog2(DEPTH):0]   free,
   output logic                     empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             wr_two;
   logic             do_pop;

   assign wr_two = push0 && push1;
   assign do_pop = pop && !empty;
   assign empty  = (count == '0);
   assign free   = CW'(DEPTH) - count;
   assign head   = empty ? '0 : mem[rd_ptr];

   // Storage is not reset; the head is masked while empty instead.
   always_ff @(posedge clk) begin
      if (push0) mem[wr_ptr] <= data0;
      if (wr_two) mem[wr_ptr + AW'(1)] <= data1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(push0) + AW'(wr_two);
         if (do_pop) rd_ptr <= rd_ptr + AW'(1);
         count  <= count + CW'(push0) + CW'(wr_two) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetcher: reads a program from DDR (two instructions per
// DDR word), buffers it in an FWFT queue and serves it to the accelerator.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start, prog_st_addr,
//   prog_inst_num            program launch (pulse, byte address, count)
//   busy, done               program in progress / final pop pulse
//   ddr_st_addr_out,
//   ddr_len, ddr_conf        DDR read request
//   ddr_fifo_empty,
//   ddr_fifo_req,
//   ddr_fifo_data            DDR read FIFO (data one cycle after req)
//   instruct, inst_req,
//   inst_empty               consumer handshake
//
// state  | meaning
// IDLE   | waiting for start; also the cycle where done is shown
// REQ    | ddr_conf strobe is out, load word counter
// FETCH  | pop DDR words into the queue while space allows
// FINISH | all pushed, wait for the consumer to drain the program
module inst_fetch #(
   parameter int INST_LEN     = hwcnn_pkg::INST_LEN,
   parameter int DDR_ADDR_LEN = 32,
   parameter int DDR_DATA_LEN = hwcnn_pkg::DDR_DATA_LEN,
   parameter int SINGLE_LEN   = 24,
   parameter int DEPTH        = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [DDR_ADDR_LEN-1:0]  prog_st_addr,
   input  logic [SINGLE_LEN-1:0]    prog_inst_num,
   output logic                     busy,
   output logic                     done,
   output logic [DDR_ADDR_LEN-1:0]  ddr_st_addr_out,
   output logic [SINGLE_LEN-1:0]    ddr_len,
   output logic                     ddr_conf,
   input  logic                     ddr_fifo_empty,
   output logic                     ddr_fifo_req,
   input  logic [DDR_DATA_LEN-1:0]  ddr_fifo_data,
   output logic [INST_LEN-1:0]      instruct,
   input  logic                     inst_req,
   output logic                     inst_empty
);
   import hwcnn_pkg::*;

   localparam int CW = $clog2(DEPTH) + 1;
   localparam int NW = SINGLE_LEN + 1;

   fetch_state_t          state;
   logic [SINGLE_LEN-1:0] inst_num;
   logic [SINGLE_LEN-1:0] words_left;
   logic [SINGLE_LEN-1:0] pushed;
   logic [SINGLE_LEN-1:0] popped;
   logic                  in_flight;

   logic [NW-1:0]         start_words;
   logic [NW-1:0]         prog_words;
   logic [SINGLE_LEN-1:0] remaining;
   logic [SINGLE_LEN-1:0] push_n;
   logic                  q_push0;
   logic                  q_push1;
   logic                  q_pop;
   logic [CW-1:0]         q_count;
   logic [CW-1:0]         q_free;
   logic [CW-1:0]         need_space;
   logic                  unused_bits;

   assign start_words = ({1'b0, prog_inst_num} + NW'(1)) >> 1;
   assign prog_words  = ({1'b0, inst_num} + NW'(1)) >> 1;
   assign remaining   = inst_num - pushed;

   // A word in flight will land two entries this cycle, so reserve for it.
   assign need_space = in_flight ? CW'(4) : CW'(2);
   assign ddr_fifo_req = (state == FETCH) && !ddr_fifo_empty &&
                         (words_left != '0) && (q_free >= need_space);

   // Slot 1 of the last word of an odd program is padding and is dropped.
   assign q_push0 = in_flight;
   assign q_push1 = in_flight && (remaining >= SINGLE_LEN'(2));
   assign push_n  = SINGLE_LEN'(q_push0) + SINGLE_LEN'(q_push1);
   assign q_pop   = inst_req && !inst_empty;

   assign unused_bits = ^{ddr_fifo_data, q_count};

   inst_queue #(
      .WIDTH (INST_LEN),
      .DEPTH (DEPTH)
   ) u_queue (
      .clk   (clk),
      .rst   (rst),
      .push0 (q_push0),
      .push1 (q_push1),
      .data0 (ddr_fifo_data[INST_LEN-1:0]),
      .data1 (ddr_fifo_data[SLOT_STRIDE +: INST_LEN]),
      .pop   (q_pop),
      .head  (instruct),
      .count (q_count),
      .free  (q_free),
      .empty (inst_empty)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state           <= IDLE;
         busy            <= 1'b0;
         done            <= 1'b0;
         ddr_conf        <= 1'b0;
         ddr_st_addr_out <= '0;
         ddr_len         <= '0;
         inst_num        <= '0;
         words_left      <= '0;
         pushed          <= '0;
         popped          <= '0;
         in_flight       <= 1'b0;
      end else begin
         in_flight <= ddr_fifo_req;
         ddr_conf  <= 1'b0;
         done      <= 1'b0;
         if (ddr_fifo_req) words_left <= words_left - SINGLE_LEN'(1);
         if (q_push0) pushed <= pushed + push_n;
         if (q_pop) popped <= popped + SINGLE_LEN'(1);

         case (state)
            IDLE: begin
               // busy is still high during the done cycle; start is ignored there.
               if (busy) begin
                  busy <= 1'b0;
               end else if (start) begin
                  busy     <= 1'b1;
                  inst_num <= prog_inst_num;
                  pushed   <= '0;
                  popped   <= '0;
                  if (prog_inst_num == '0) begin
                     state <= FINISH;
                  end else begin
                     state           <= REQ;
                     ddr_conf        <= 1'b1;
                     ddr_st_addr_out <= prog_st_addr;
                     ddr_len         <= SINGLE_LEN'(start_words << $clog2(BYTES_PER_WORD));
                  end
               end
            end
            REQ: begin
               words_left <= SINGLE_LEN'(prog_words);
               state      <= FETCH;
            end
            FETCH: begin
               if (q_push0 && (pushed + push_n == inst_num)) state <= FINISH;
            end
            FINISH: begin
               if (popped + SINGLE_LEN'(q_pop) == inst_num) begin
                  done  <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: DDR read FIFO model, consumer model and
// hand-computed expectations for several program lengths.
module tb_inst_fetch;
   localparam int INST_LEN = 220;
   localparam int AL       = 32;
   localparam int DL       = 512;
   localparam int SL       = 24;
   localparam int DEPTH    = 16;

   logic            clk = 1'b0;
   logic            rst;
   logic            start;
   logic [AL-1:0]   prog_st_addr;
   logic [SL-1:0]   prog_inst_num;
   logic            busy;
   logic            done;
   logic [AL-1:0]   ddr_st_addr_out;
   logic [SL-1:0]   ddr_len;
   logic            ddr_conf;
   logic            ddr_fifo_empty;
   logic            ddr_fifo_req;
   logic [DL-1:0]   ddr_fifo_data;
   logic [INST_LEN-1:0] instruct;
   logic            inst_req;
   logic            inst_empty;

   inst_fetch dut (
      .clk             (clk),
      .rst             (rst),
      .start           (start),
      .prog_st_addr    (prog_st_addr),
      .prog_inst_num   (prog_inst_num),
      .busy            (busy),
      .done            (done),
      .ddr_st_addr_out (ddr_st_addr_out),
      .ddr_len         (ddr_len),
      .ddr_conf        (ddr_conf),
      .ddr_fifo_empty  (ddr_fifo_empty),
      .ddr_fifo_req    (ddr_fifo_req),
      .ddr_fifo_data   (ddr_fifo_data),
      .instruct        (instruct),
      .inst_req        (inst_req),
      .inst_empty      (inst_empty)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [INST_LEN-1:0] inst_val(input int i);
      logic [23:0] k;
      k = 24'(i);
      return {k ^ 24'hABCDEF, {43{4'h3}}, k};
   endfunction

   function automatic logic [DL-1:0] make_word(input int w);
      return {36'hFFFFFFFFF, inst_val(2*w+1), 36'hFFFFFFFFF, inst_val(2*w)};
   endfunction

   int cyc, n_conf, n_req, n_done, n_busy, pop_idx, word_idx, pop_left;
   int conf_cyc, done_cyc, last_pop_cyc, max_cnt, empty_mode, t;
   logic [SL-1:0] last_len;
   logic [AL-1:0] last_addr;
   logic          req_now;

   task automatic clear_stats();
      n_conf = 0; n_req = 0; n_done = 0; n_busy = 0; pop_idx = 0; word_idx = 0;
      conf_cyc = -1; done_cyc = -1; last_pop_cyc = -1; max_cnt = 0;
      last_len = '0; last_addr = '0;
   endtask

   // One clock: sample at negedge, then drive the next cycle's inputs after posedge.
   task automatic step();
      @(negedge clk);
      req_now = ddr_fifo_req;
      if (ddr_conf) begin n_conf++; conf_cyc = cyc; last_len = ddr_len; last_addr = ddr_st_addr_out; end
      if (ddr_fifo_req) n_req++;
      if (done) begin n_done++; done_cyc = cyc; end
      if (busy) n_busy++;
      if (inst_req && !inst_empty) begin
         check_val("inst_order", 256'(instruct), 256'(inst_val(pop_idx)));
         pop_idx++;
         last_pop_cyc = cyc;
         if (pop_left > 0) pop_left--;
      end
      if (int'(dut.u_queue.count) > max_cnt) max_cnt = int'(dut.u_queue.count);
      if (int'(dut.u_queue.count) > DEPTH) check_val("q_overflow", 256'(dut.u_queue.count), DEPTH);
      @(posedge clk);
      #1;
      cyc++;
      if (req_now) begin ddr_fifo_data = make_word(word_idx); word_idx++; end
      ddr_fifo_empty = (empty_mode != 0) ? (cyc % 2 == 1) : 1'b0;
      inst_req = (pop_left != 0);
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; pop_left = 0; inst_req = 1'b0; empty_mode = 0;
      step(); step();
      rst = 1'b0;
      clear_stats();
   endtask

   task automatic start_prog(input logic [AL-1:0] addr, input int n, output int t0);
      prog_st_addr = addr; prog_inst_num = SL'(n); start = 1'b1;
      t0 = cyc;
      step();
      start = 1'b0;
   endtask

   task automatic run_until_done(input int budget, input string tag);
      int k;
      k = 0;
      while (n_done == 0 && k < budget) begin step(); k++; end
      if (n_done == 0) check_val({tag, "_timeout"}, 0, 1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_busy"}, 256'(busy), 0);
      check_val({tag, "_done"}, 256'(done), 0);
      check_val({tag, "_conf"}, 256'(ddr_conf), 0);
      check_val({tag, "_addr"}, 256'(ddr_st_addr_out), 0);
      check_val({tag, "_len"}, 256'(ddr_len), 0);
      check_val({tag, "_freq"}, 256'(ddr_fifo_req), 0);
      check_val({tag, "_instr"}, 256'(instruct), 0);
      check_val({tag, "_empty"}, 256'(inst_empty), 1);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; inst_req = 1'b0; ddr_fifo_empty = 1'b1; ddr_fifo_data = '0;
      prog_st_addr = '0; prog_inst_num = '0; cyc = 0; pop_left = 0; empty_mode = 0;
      clear_stats();
      do_reset();
      check_reset_outputs("rst");

      // Pops while empty must not move the queue
      pop_left = -1; inst_req = 1'b1;
      step(); step(); step();
      check_val("empty_pop_cnt", 256'(dut.u_queue.count), 0);
      check_val("empty_pop_flag", 256'(inst_empty), 1);

      // n=4, free-running consumer, second start ignored
      do_reset();
      pop_left = -1;
      start_prog(32'h1000, 4, t);
      step(); step();
      prog_st_addr = 32'h5000; prog_inst_num = 24'd7; start = 1'b1;
      step();
      start = 1'b0;
      run_until_done(100, "n4");
      repeat (5) step();
      check_val("n4_conf_cyc", conf_cyc, t + 1);
      check_val("n4_conf_cnt", n_conf, 1);
      check_val("n4_len", 256'(last_len), 128);
      check_val("n4_addr", 256'(last_addr), 32'h1000);
      check_val("n4_req_cnt", n_req, 2);
      check_val("n4_pops", pop_idx, 4);
      check_val("n4_done_cyc", done_cyc, last_pop_cyc + 1);
      check_val("n4_done_cnt", n_done, 1);
      check_val("n4_busy_after", 256'(busy), 0);
      check_val("n4_empty_after", 256'(inst_empty), 1);

      // n=5 with a gappy DDR FIFO: last word only yields slot 0
      do_reset();
      pop_left = -1; empty_mode = 1;
      start_prog(32'h4000, 5, t);
      run_until_done(200, "n5");
      repeat (5) step();
      check_val("n5_len", 256'(last_len), 192);
      check_val("n5_req_cnt", n_req, 3);
      check_val("n5_pops", pop_idx, 5);
      check_val("n5_done_cnt", n_done, 1);
      check_val("n5_q_left", 256'(dut.u_queue.count), 0);

      // n=40 with stalled consumer: fill, release two, drain
      do_reset();
      start_prog(32'h2000, 40, t);
      repeat (30) step();
      check_val("n40_fill", max_cnt, 16);
      check_val("n40_req_stall", n_req, 8);
      check_val("n40_req_idle", 256'(req_now), 0);
      pop_left = 2; inst_req = 1'b1;
      repeat (10) step();
      check_val("n40_refetch", n_req, 9);
      check_val("n40_two_pops", pop_idx, 2);
      check_val("n40_refill", 256'(dut.u_queue.count), 16);
      pop_left = -1; inst_req = 1'b1;
      run_until_done(300, "n40");
      step();
      check_val("n40_pops", pop_idx, 40);
      check_val("n40_req_cnt", n_req, 20);
      check_val("n40_len", 256'(last_len), 1280);
      check_val("n40_done_cnt", n_done, 1);

      // n=0: no DDR traffic, done two cycles after start
      do_reset();
      start_prog(32'h0, 0, t);
      run_until_done(20, "n0");
      repeat (3) step();
      check_val("n0_conf_cnt", n_conf, 0);
      check_val("n0_req_cnt", n_req, 0);
      check_val("n0_done_cyc", done_cyc, t + 2);
      check_val("n0_busy_cycles", n_busy, 2);
      check_val("n0_busy_after", 256'(busy), 0);

      // Reset in the middle of FETCH, then a fresh n=2 program
      do_reset();
      start_prog(32'h6000, 40, t);
      repeat (6) step();
      rst = 1'b1;
      step();
      check_reset_outputs("midrst");
      check_val("midrst_q_cnt", 256'(dut.u_queue.count), 0);
      check_val("midrst_no_done", n_done, 0);
      rst = 1'b0;
      clear_stats();
      pop_left = -1;
      start_prog(32'h3000, 2, t);
      run_until_done(100, "post");
      repeat (3) step();
      check_val("post_addr", 256'(last_addr), 32'h3000);
      check_val("post_len", 256'(last_len), 64);
      check_val("post_req_cnt", n_req, 1);
      check_val("post_pops", pop_idx, 2);
      check_val("post_done_cnt", n_done, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
